// File: rtl/magic_glove_pkg.sv
// Types and constants shared by the word buffer and the VGA glyph renderer.
package magic_glove_pkg;

  localparam int DEPTH   = 31;
  localparam int CODE_W  = 8;
  localparam int CNT_W   = 5;
  localparam int ENTRIES = 32;

  localparam logic [CODE_W-1:0] PAT_NONE   = 8'd0;
  localparam logic [CODE_W-1:0] PAT_SQUARE = 8'd1;
  localparam logic [CODE_W-1:0] PAT_A      = 8'd2;
  localparam logic [CODE_W-1:0] PAT_B      = 8'd3;

  typedef enum logic [1:0] {
    CMD_NOP       = 2'd0,
    CMD_APPEND    = 2'd1,
    CMD_BACKSPACE = 2'd2,
    CMD_CLEAR     = 2'd3
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/word_buffer.sv
// Double-buffered word store: commands edit the back copy, and the renderer sees a
// front copy that only changes on a frame boundary so a word never tears mid-frame.
module word_buffer
  import magic_glove_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [1:0]                i_cmd,
  input  logic [CODE_W-1:0]         i_code,
  input  logic                      i_frame_start,
  output logic [CNT_W-1:0]          o_word_cnt,
  output logic [ENTRIES*CODE_W-1:0] o_pattern_num,
  output logic                      o_full,
  output logic                      o_overflow
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  back_cnt_q, back_cnt_d;
  logic [CNT_W-1:0]  front_cnt_q, front_cnt_d;
  logic              overflow_q, overflow_d;
  logic              copy_pend_q, copy_pend_d;
  logic [CODE_W-1:0] back_mem_q  [DEPTH];
  logic [CODE_W-1:0] back_mem_d  [DEPTH];
  logic [CODE_W-1:0] front_mem_q [DEPTH];
  logic [CODE_W-1:0] front_mem_d [DEPTH];

  logic              accept;
  logic [CNT_W-1:0]  last_idx;

  assign accept   = i_valid && (state_q == ST_IDLE);
  assign last_idx = back_cnt_q - 5'd1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    back_cnt_d  = back_cnt_q;
    front_cnt_d = front_cnt_q;
    overflow_d  = overflow_q;
    copy_pend_d = copy_pend_q;
    back_mem_d  = back_mem_q;
    front_mem_d = front_mem_q;

    case (state_q)
      ST_IDLE: begin
        // Snapshot uses the registered back state, i.e. before any coincident command.
        if (i_frame_start || copy_pend_q) begin
          front_mem_d = back_mem_q;
          front_cnt_d = back_cnt_q;
          copy_pend_d = 1'b0;
        end
        if (accept) begin
          case (cmd_e'(i_cmd))
            CMD_APPEND: begin
              if (i_code != PAT_NONE) begin
                if (back_cnt_q < CNT_W'(DEPTH)) begin
                  back_mem_d[back_cnt_q] = i_code;
                  back_cnt_d             = back_cnt_q + 5'd1;
                end else begin
                  overflow_d = 1'b1;
                end
              end
            end
            CMD_BACKSPACE: begin
              if (back_cnt_q != '0) begin
                back_mem_d[last_idx] = PAT_NONE;
                back_cnt_d           = last_idx;
              end
            end
            CMD_CLEAR: begin
              back_cnt_d = '0;
              overflow_d = 1'b0;
              ptr_d      = '0;
              state_d    = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        back_mem_d[ptr_q] = PAT_NONE;
        if (i_frame_start) copy_pend_d = 1'b1;
        if (ptr_q == CNT_W'(DEPTH - 1)) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      back_cnt_q  <= '0;
      front_cnt_q <= '0;
      overflow_q  <= 1'b0;
      copy_pend_q <= 1'b0;
      back_mem_q  <= '{default: '0};
      front_mem_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      back_cnt_q  <= back_cnt_d;
      front_cnt_q <= front_cnt_d;
      overflow_q  <= overflow_d;
      copy_pend_q <= copy_pend_d;
      back_mem_q  <= back_mem_d;
      front_mem_q <= front_mem_d;
    end
  end

  // The last renderer slot has no storage behind it and reads as PAT_NONE.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_out
      if (gi < DEPTH) begin : g_used
        assign o_pattern_num[gi*CODE_W +: CODE_W] = front_mem_q[gi];
      end else begin : g_none
        assign o_pattern_num[gi*CODE_W +: CODE_W] = PAT_NONE;
      end
    end
  endgenerate

  assign o_ready    = (state_q == ST_IDLE);
  assign o_full     = (back_cnt_q == CNT_W'(DEPTH));
  assign o_word_cnt = front_cnt_q;
  assign o_overflow = overflow_q;

endmodule
